// File: rtl/addr_mgmt_pkg.sv
// Shared constants, state encodings and helpers for the packet buffer slot manager.
// Contents: slot/line geometry, line tag codes, init/write/read FSM encodings, and
// slot_base() which maps a slot index to its first RAM line address.
package addr_mgmt_pkg;

    localparam int unsigned SLOT_W    = 6;
    localparam int unsigned LINE_W    = 5;
    localparam int unsigned ADDR_W    = SLOT_W + LINE_W;
    localparam int unsigned NUM_SLOTS = 1 << SLOT_W;

    localparam logic [1:0] TAG_HEAD = 2'b01;
    localparam logic [1:0] TAG_MID  = 2'b11;
    localparam logic [1:0] TAG_TAIL = 2'b10;

    typedef enum logic {StInit, StRun} init_st_e;
    typedef enum logic {StWIdle, StWPkt} wr_st_e;
    typedef enum logic [1:0] {StRIdle, StRBusy, StRGap} rd_st_e;

    function automatic logic [ADDR_W-1:0] slot_base(input logic [SLOT_W-1:0] slot);
        return {slot, {LINE_W{1'b0}}};
    endfunction

endpackage

// File: rtl/addr_mgmt_if.sv
// Packet-side and read-engine-side signal bundle of addr_mgmt.
// slave modport: the slot manager (tags, rd_done, out_ready in; addresses, pulses, counts out).
// master modport: the environment driving packet tags and read-engine handshakes.
interface addr_mgmt_if;
    import addr_mgmt_pkg::*;

    logic [1:0]        in_pkt_tag;
    logic              in_pkt_wr;
    logic [ADDR_W-1:0] addr2data_waddr;
    logic              addr2data_waddr_wr;
    logic [ADDR_W-1:0] addr2data_raddr;
    logic              addr2data_raddr_wr;
    logic              rd_done;
    logic              out_ready;
    logic              out_pkt_drop;
    logic              out_pkt_err;
    logic [SLOT_W:0]   free_cnt;
    logic [SLOT_W:0]   pkt_cnt;

    modport slave (
        input  in_pkt_tag, in_pkt_wr, rd_done, out_ready,
        output addr2data_waddr, addr2data_waddr_wr, addr2data_raddr, addr2data_raddr_wr,
        output out_pkt_drop, out_pkt_err, free_cnt, pkt_cnt
    );

    modport master (
        output in_pkt_tag, in_pkt_wr, rd_done, out_ready,
        input  addr2data_waddr, addr2data_waddr_wr, addr2data_raddr, addr2data_raddr_wr,
        input  out_pkt_drop, out_pkt_err, free_cnt, pkt_cnt
    );

endinterface

// File: rtl/addr_mgmt_slot_fifo.sv
// FIFO of slot indices, NUM_SLOTS deep, used for both the free list and the descriptor queue.
// Ports: clk, rst_n; push/din write; pop advances and loads dout (valid the cycle after pop);
// empty, full, count reflect occupancy. Push and pop may coincide; callers never pop when empty.
module addr_mgmt_slot_fifo
    import addr_mgmt_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [SLOT_W-1:0] din,
    output logic [SLOT_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic [SLOT_W:0]   count
);

    logic [SLOT_W-1:0] mem_q [NUM_SLOTS];
    logic [SLOT_W-1:0] wptr_q, rptr_q, dout_q;
    logic [SLOT_W:0]   count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            dout_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + SLOT_W'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + SLOT_W'(1);
                dout_q <= mem_q[rptr_q];
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + (SLOT_W+1)'(1);
                2'b01:   count_q <= count_q - (SLOT_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout  = dout_q;
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == (SLOT_W+1)'(NUM_SLOTS));

endmodule

// File: rtl/addr_mgmt.sv
// Buffer-slot manager and read scheduler for the packet data RAM.
// Ports: clk, rst_n (async, active-low); bus (addr_mgmt_if.slave) carrying packet tags,
// write/read base addresses, read-engine handshake, drop/error pulses and slot counters.
// After reset all slot IDs are loaded into the free list; one slot is kept reserved for the
// next packet head, committed packets queue in order and are read one at a time.
module addr_mgmt
    import addr_mgmt_pkg::*;
(
    input logic        clk,
    input logic        rst_n,
    addr_mgmt_if.slave bus
);

    init_st_e          init_st_q, init_st_d;
    wr_st_e            wr_st_q, wr_st_d;
    rd_st_e            rd_st_q, rd_st_d;
    logic [SLOT_W-1:0] init_cnt_q, init_cnt_d;
    logic [SLOT_W-1:0] cur_slot_q, cur_slot_d;
    // pend_q: a slot was popped last cycle and lands in resv_q this cycle.
    logic              pend_q, pend_d;
    logic              resv_q, resv_d;
    logic              drop_q, drop_d;
    logic              err_q, err_d;
    logic              raddr_wr_q, raddr_wr_d;

    logic              free_push, free_pop, free_empty, free_full;
    logic [SLOT_W-1:0] free_din, free_dout;
    logic [SLOT_W:0]   free_count;
    logic              desc_push, desc_pop, desc_empty, desc_full;
    logic [SLOT_W-1:0] desc_dout;
    logic [SLOT_W:0]   desc_count;
    logic              in_init, head, take, release_slot;

    addr_mgmt_slot_fifo u_free_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (free_push),
        .pop   (free_pop),
        .din   (free_din),
        .dout  (free_dout),
        .empty (free_empty),
        .full  (free_full),
        .count (free_count)
    );

    addr_mgmt_slot_fifo u_desc_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (desc_push),
        .pop   (desc_pop),
        .din   (cur_slot_q),
        .dout  (desc_dout),
        .empty (desc_empty),
        .full  (desc_full),
        .count (desc_count)
    );

    always_comb begin
        init_st_d    = init_st_q;
        init_cnt_d   = init_cnt_q;
        wr_st_d      = wr_st_q;
        rd_st_d      = rd_st_q;
        cur_slot_d   = cur_slot_q;
        drop_d       = 1'b0;
        err_d        = 1'b0;
        desc_push    = 1'b0;
        desc_pop     = 1'b0;
        take         = 1'b0;
        release_slot = 1'b0;

        in_init = (init_st_q == StInit);
        head    = bus.in_pkt_wr && (bus.in_pkt_tag == TAG_HEAD);

        if (in_init) begin
            init_cnt_d = init_cnt_q + SLOT_W'(1);
            if (init_cnt_q == '1) begin
                init_st_d = StRun;
            end
        end

        unique case (wr_st_q)
            StWIdle: begin
                if (head) begin
                    if (resv_q) begin
                        take       = 1'b1;
                        cur_slot_d = free_dout;
                        wr_st_d    = StWPkt;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
            StWPkt: begin
                if (bus.in_pkt_wr) begin
                    unique case (bus.in_pkt_tag)
                        // Restarting inside an open packet keeps the current slot.
                        TAG_HEAD: err_d = 1'b1;
                        TAG_TAIL: begin
                            desc_push = !desc_full;
                            wr_st_d   = StWIdle;
                        end
                        TAG_MID, 2'b00: ;
                    endcase
                end
            end
            default: wr_st_d = StWIdle;
        endcase

        unique case (rd_st_q)
            StRIdle: begin
                if (!desc_empty && bus.out_ready && !in_init) begin
                    desc_pop = 1'b1;
                    rd_st_d  = StRBusy;
                end
            end
            StRBusy: begin
                if (bus.rd_done) begin
                    release_slot = 1'b1;
                    rd_st_d      = StRGap;
                end
            end
            StRGap:  rd_st_d = StRIdle;
            default: rd_st_d = StRIdle;
        endcase

        // desc_dout holds the slot being read for the whole busy phase.
        free_push = (in_init || release_slot) && !free_full;
        free_din  = in_init ? init_cnt_q : desc_dout;
        free_pop  = !in_init && !resv_q && !pend_q && !free_empty;

        pend_d = free_pop;
        resv_d = resv_q;
        if (pend_q) begin
            resv_d = 1'b1;
        end
        if (take) begin
            resv_d = 1'b0;
        end
        raddr_wr_d = desc_pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_st_q  <= StInit;
            wr_st_q    <= StWIdle;
            rd_st_q    <= StRIdle;
            init_cnt_q <= '0;
            cur_slot_q <= '0;
            pend_q     <= 1'b0;
            resv_q     <= 1'b0;
            drop_q     <= 1'b0;
            err_q      <= 1'b0;
            raddr_wr_q <= 1'b0;
        end else begin
            init_st_q  <= init_st_d;
            wr_st_q    <= wr_st_d;
            rd_st_q    <= rd_st_d;
            init_cnt_q <= init_cnt_d;
            cur_slot_q <= cur_slot_d;
            pend_q     <= pend_d;
            resv_q     <= resv_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
            raddr_wr_q <= raddr_wr_d;
        end
    end

    assign bus.addr2data_waddr    = slot_base(free_dout);
    assign bus.addr2data_waddr_wr = resv_q;
    assign bus.addr2data_raddr    = slot_base(desc_dout);
    assign bus.addr2data_raddr_wr = raddr_wr_q;
    assign bus.out_pkt_drop       = drop_q;
    assign bus.out_pkt_err        = err_q;
    // A slot in flight from the free list to the reservation still counts as free.
    assign bus.free_cnt           = free_count + {{SLOT_W{1'b0}}, resv_q | pend_q};
    assign bus.pkt_cnt            = desc_count;

endmodule
